// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction memory read initiator with a prefetch FIFO.
// Drives the fetch Address, waits WAIT_CYCLES edges for the memory read to
// settle, captures Data with its PC into the FIFO, and hands entries to decode
// over a valid/ready handshake. A branch redirect flushes everything and
// restarts fetch.
//
// Optional feature: define IFU_XCHECK_EN (simulation only) to trap X/Z read
// data into a sticky FAULT state instead of pushing it.
//
// state | meaning
// IDLE  | out of reset, loads startpc on the first edge
// WAIT  | counting read latency for the current Address
// HOLD  | read complete but FIFO full; Address held so Data stays valid
// FAULT | X/Z data seen (IFU_XCHECK_EN only); FIFO drains, fetch stopped
module instr_fetch_unit #(
    parameter int WAIT_CYCLES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic [63:0] startpc,
    output logic [63:0] Address,
    input  logic [31:0] Data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
`ifdef IFU_XCHECK_EN
        , S_FAULT
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [63:0]        r_addr;
    logic [31:0]        r_fifo_word [FIFO_DEPTH];
    logic [63:0]        r_fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic w_active;
    logic w_redirect;
    logic w_capture;
    logic w_pop;
    logic w_full;
    logic w_data_bad;
    logic w_push;
    logic w_hold;

    // Redirect wins over capture and pop; a bad word is never pushed.
    assign w_active   = (r_state == S_WAIT) || (r_state == S_HOLD);
    assign w_redirect = redirect && w_active;
    assign w_capture  = w_active && (r_cnt == '0);
    assign w_pop      = (r_count != '0) && instr_ready;
    assign w_full     = (r_count == FIFO_FULL);
`ifdef IFU_XCHECK_EN
    assign w_data_bad = $isunknown(Data);
`else
    assign w_data_bad = 1'b0;
`endif
    assign w_push = w_capture && !w_redirect && !w_data_bad && (!w_full || w_pop);
    assign w_hold = w_capture && !w_redirect && !w_data_bad && w_full && !w_pop;

    // State register.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: w_next_state = S_WAIT;
            S_WAIT, S_HOLD: begin
                if (w_redirect) begin
                    w_next_state = S_WAIT;
`ifdef IFU_XCHECK_EN
                end else if (w_capture && w_data_bad) begin
                    w_next_state = S_FAULT;
`endif
                end else if (w_push) begin
                    w_next_state = S_WAIT;
                end else if (w_hold) begin
                    w_next_state = S_HOLD;
                end
            end
            default: w_next_state = r_state;
        endcase
    end

    // Outputs come straight from registered FIFO storage and the address register.
    always_comb begin
        Address     = r_addr;
        instr_valid = (r_count != '0);
        instr       = r_fifo_word[r_rd_ptr];
        instr_pc    = r_fifo_pc[r_rd_ptr];
`ifdef IFU_XCHECK_EN
        fetch_fault = (r_state == S_FAULT);
`else
        fetch_fault = 1'b0;
`endif
    end

    // Fetch address and read-latency down-counter.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_addr <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_addr <= startpc;
                    r_cnt  <= CNT_RELOAD;
                end
                S_WAIT, S_HOLD: begin
                    if (w_redirect) begin
                        r_addr <= redirect_pc;
                        r_cnt  <= CNT_RELOAD;
                    end else if (w_push) begin
                        r_addr <= r_addr + 64'd4;
                        r_cnt  <= CNT_RELOAD;
                    end else if (!w_capture) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_addr <= r_addr;
                    r_cnt  <= r_cnt;
                end
            endcase
        end
    end

    // Prefetch FIFO: push captured {pc, word}, pop on handshake, flush on redirect.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_word[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (w_redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_word[r_wr_ptr] <= Data;
                r_fifo_pc[r_wr_ptr]   <= r_addr;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit (WAIT_CYCLES=2, FIFO_DEPTH=4).
// A small ROM function stands in for instruction memory; addresses
// 0x064..0xFFF read back as an all-X word.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        resetl;
    logic [63:0] startpc;
    logic [63:0] Address;
    logic [31:0] Data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        fetch_fault;

    logic [31:0] x_word;
    int          n_tests = 0;
    int          n_fail  = 0;

    instr_fetch_unit #(.WAIT_CYCLES(2), .FIFO_DEPTH(4)) dut (
        .CLK         (CLK),
        .resetl      (resetl),
        .startpc     (startpc),
        .Address     (Address),
        .Data        (Data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_fault (fetch_fault)
    );

    function automatic logic [31:0] rom(input logic [63:0] a);
        case (a)
            64'h00:  rom = 32'hF84003E9;
            64'h04:  rom = 32'hF84083EA;
            64'h08:  rom = 32'hF84103EB;
            64'h0C:  rom = 32'hF84183EC;
            64'h10:  rom = 32'hF84203ED;
            64'h28:  rom = 32'h17FFFFFD;
            64'h2C:  rom = 32'hF80203ED;
            64'h38:  rom = 32'h8B1F03E9;
            default: rom = {16'hA5A5, a[15:0]};
        endcase
    endfunction

    assign Data = (Address[63:12] == '0 && Address[11:0] >= 12'h064) ? x_word : rom(Address);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        x_word      = 'x;
        resetl      = 1'b1;
        startpc     = 64'h0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        #1 resetl = 1'b0;
        #1;
        check("rst_addr",  Address, 64'h0);
        check("rst_valid", {63'h0, instr_valid}, 64'h0);
        check("rst_instr", {32'h0, instr}, 64'h0);
        check("rst_pc",    instr_pc, 64'h0);
        check("rst_fault", {63'h0, fetch_fault}, 64'h0);
        tick(); tick();

        // Cold start, decode always ready.
        resetl = 1'b1;
        tick();
        check("cold_e1_addr",  Address, 64'h0);
        check("cold_e1_valid", {63'h0, instr_valid}, 64'h0);
        tick();
        check("cold_e2_valid", {63'h0, instr_valid}, 64'h0);
        tick();
        check("cold_e3_valid", {63'h0, instr_valid}, 64'h1);
        check("cold_e3_instr", {32'h0, instr}, 64'hF84003E9);
        check("cold_e3_pc",    instr_pc, 64'h0);
        tick(); tick();
        check("cold_w1_instr", {32'h0, instr}, 64'hF84083EA);
        check("cold_w1_pc",    instr_pc, 64'h4);
        tick(); tick();
        check("cold_w2_instr", {32'h0, instr}, 64'hF84103EB);
        check("cold_w2_pc",    instr_pc, 64'h8);

        // Back-pressure from reset: fill, hold, then pop on capture edges.
        resetl = 1'b0; instr_ready = 1'b0; startpc = 64'h0;
        #1;
        check("bp_rst_addr",  Address, 64'h0);
        check("bp_rst_valid", {63'h0, instr_valid}, 64'h0);
        tick();
        resetl = 1'b1;
        repeat (12) tick();
        check("bp_full_addr", Address, 64'h10);
        check("bp_full_pc",   instr_pc, 64'h0);
        check("bp_full_instr", {32'h0, instr}, 64'hF84003E9);
        repeat (3) tick();
        check("bp_hold_addr", Address, 64'h10);
        instr_ready = 1'b1;
        tick();
        check("bp_pp1_pc",   instr_pc, 64'h4);
        check("bp_pp1_addr", Address, 64'h14);
        instr_ready = 1'b0;
        tick(); tick();
        check("bp_still_full_addr", Address, 64'h14);
        check("bp_still_full_pc",   instr_pc, 64'h4);
        instr_ready = 1'b1;
        tick();
        check("bp_pp2_pc",   instr_pc, 64'h8);
        check("bp_pp2_addr", Address, 64'h18);
        tick();
        check("bp_d_pc_c",   instr_pc, 64'hC);
        tick();
        check("bp_d_pc_10",  instr_pc, 64'h10);
        check("bp_d_w_10",   {32'h0, instr}, 64'hF84203ED);

        // Redirect with one entry queued and a read in flight.
        resetl = 1'b0; instr_ready = 1'b0;
        #1;
        tick();
        resetl = 1'b1;
        repeat (3) tick();
        check("rd_queued_valid", {63'h0, instr_valid}, 64'h1);
        check("rd_queued_pc",    instr_pc, 64'h0);
        redirect = 1'b1; redirect_pc = 64'h28;
        tick();
        redirect = 1'b0;
        check("rd_flush_valid", {63'h0, instr_valid}, 64'h0);
        check("rd_flush_addr",  Address, 64'h28);
        tick();
        check("rd_gap_valid", {63'h0, instr_valid}, 64'h0);
        tick();
        check("rd_first_valid", {63'h0, instr_valid}, 64'h1);
        check("rd_first_instr", {32'h0, instr}, 64'h17FFFFFD);
        check("rd_first_pc",    instr_pc, 64'h28);
        instr_ready = 1'b1;
        tick(); tick();
        check("rd_second_instr", {32'h0, instr}, 64'hF80203ED);
        check("rd_second_pc",    instr_pc, 64'h2C);

        // Back-to-back redirects: the last target wins.
        redirect = 1'b1; redirect_pc = 64'h40;
        tick();
        redirect_pc = 64'h10;
        tick();
        redirect = 1'b0;
        check("rr_addr",  Address, 64'h10);
        check("rr_valid", {63'h0, instr_valid}, 64'h0);
        tick(); tick();
        check("rr_pc",    instr_pc, 64'h10);
        check("rr_instr", {32'h0, instr}, 64'hF84203ED);

        // Reset mid-WAIT, restart from a new startpc.
        tick();
        #2 resetl = 1'b0;
        #1;
        check("mid_rst_addr",  Address, 64'h0);
        check("mid_rst_valid", {63'h0, instr_valid}, 64'h0);
        startpc = 64'h38;
        tick();
        resetl = 1'b1;
        repeat (3) tick();
        check("restart_valid", {63'h0, instr_valid}, 64'h1);
        check("restart_instr", {32'h0, instr}, 64'h8B1F03E9);
        check("restart_pc",    instr_pc, 64'h38);

        // Address wrap at the top of the 64-bit space.
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wrap_addr_pre", Address, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); tick();
        check("wrap_addr_post", Address, 64'h0);
        check("wrap_pc",        instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_instr",     {32'h0, instr}, 64'hA5A5FFFC);

        // Unmapped fetch returning an all-X word.
        instr_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 64'h64;
        tick();
        redirect = 1'b0;
        tick(); tick();
`ifdef IFU_XCHECK_EN
        check("xchk_fault", {63'h0, fetch_fault}, 64'h1);
        check("xchk_valid", {63'h0, instr_valid}, 64'h0);
        check("xchk_addr",  Address, 64'h64);
        redirect = 1'b1; redirect_pc = 64'h0;
        tick();
        redirect = 1'b0;
        tick();
        check("xchk_redir_ignored", Address, 64'h64);
        check("xchk_sticky",        {63'h0, fetch_fault}, 64'h1);
`else
        check("unmap_valid", {63'h0, instr_valid}, 64'h1);
        check("unmap_instr", {32'h0, instr}, {32'h0, x_word});
        check("unmap_pc",    instr_pc, 64'h64);
        check("unmap_fault", {63'h0, fetch_fault}, 64'h0);
        check("unmap_addr",  Address, 64'h68);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
